// File: rtl/ddr_arw_pkg.sv
// Shared definitions for the DDR ARW arbiter: payload field widths, default ID base,
// output-slot state encoding and an index-width helper.
package ddr_arw_pkg;

  localparam int unsigned LenW   = 8;
  localparam int unsigned SizeW  = 3;
  localparam int unsigned BurstW = 2;
  localparam int unsigned LockW  = 2;
  localparam int unsigned IdW    = 8;
  localparam int unsigned CntW   = 4;

  localparam logic [IdW-1:0] IdBaseDefault = 8'hE0;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_e;

  // Index width with a floor of one bit so single-entry cases still get a real vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_arw_arbiter_if.sv
// Bundle of requester, DDR ARW and completion/status signals around the ARW arbiter.
// The slave modport is the arbiter's view; master is the surrounding DMA/DDR side.
interface ddr_arw_arbiter_if
  import ddr_arw_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned AW        = 32
);
  localparam int unsigned PW = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*AW-1:0]     req_addr;
  logic [NUM_PORTS*LenW-1:0]   req_len;
  logic [NUM_PORTS*SizeW-1:0]  req_size;
  logic [NUM_PORTS*BurstW-1:0] req_burst;
  logic [NUM_PORTS*LockW-1:0]  req_lock;

  logic              io_ddr_arw_valid;
  logic              io_ddr_arw_ready;
  logic [AW-1:0]     io_ddr_arw_payload_addr;
  logic [IdW-1:0]    io_ddr_arw_payload_id;
  logic [LenW-1:0]   io_ddr_arw_payload_len;
  logic [SizeW-1:0]  io_ddr_arw_payload_size;
  logic [BurstW-1:0] io_ddr_arw_payload_burst;
  logic [LockW-1:0]  io_ddr_arw_payload_lock;
  logic              io_ddr_arw_payload_write;

  logic            w_last_fire;
  logic            b_fire;
  logic            r_last_fire;
  logic            wr_order_valid;
  logic [PW-1:0]   wr_order_port;
  logic [CntW-1:0] wr_outs;
  logic [CntW-1:0] rd_outs;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_size, req_burst, req_lock,
    output req_ready,
    output io_ddr_arw_valid, io_ddr_arw_payload_addr, io_ddr_arw_payload_id,
    output io_ddr_arw_payload_len, io_ddr_arw_payload_size, io_ddr_arw_payload_burst,
    output io_ddr_arw_payload_lock, io_ddr_arw_payload_write,
    input  io_ddr_arw_ready,
    input  w_last_fire, b_fire, r_last_fire,
    output wr_order_valid, wr_order_port, wr_outs, rd_outs
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, req_size, req_burst, req_lock,
    input  req_ready,
    input  io_ddr_arw_valid, io_ddr_arw_payload_addr, io_ddr_arw_payload_id,
    input  io_ddr_arw_payload_len, io_ddr_arw_payload_size, io_ddr_arw_payload_burst,
    input  io_ddr_arw_payload_lock, io_ddr_arw_payload_write,
    output io_ddr_arw_ready,
    output w_last_fire, b_fire, r_last_fire,
    input  wr_order_valid, wr_order_port, wr_outs, rd_outs
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr_i, else lowest set request.
module rr_arbiter #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned PtrW     = 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [PtrW-1:0]     ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PtrW-1:0]     idx_o,
  output logic                valid_o
);

  logic            hi_found;
  logic [PtrW-1:0] hi_idx;
  logic [PtrW-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    valid_o  = 1'b0;
    // Descending scan: the last hit written is the lowest index in each class.
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        lo_idx  = PtrW'(i);
        if (PtrW'(i) >= ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = PtrW'(i);
        end
      end
    end
    idx_o = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < int'(NumPorts); i++) begin
      gnt_o[i] = valid_o && (idx_o == PtrW'(i));
    end
  end

endmodule

// File: rtl/ddr_arw_arbiter.sv
// N-port round-robin merge of read/write address requests onto one registered DDR ARW slot,
// with per-direction outstanding limits and a write-order FIFO. ARW_ARB_WR_PRIORITY_EN: writes first.
module ddr_arw_arbiter
  import ddr_arw_pkg::*;
#(
  parameter int unsigned    NUM_PORTS = 2,
  parameter int unsigned    AW        = 32,
  parameter int unsigned    MAX_OUTS  = 4,
  parameter logic [IdW-1:0] ID_BASE   = IdBaseDefault
) (
  input logic               dma_clk,
  input logic               dma_reset,
  ddr_arw_arbiter_if.slave  bus
);

  localparam int unsigned PW     = idx_width(NUM_PORTS);
  localparam int unsigned QW     = idx_width(MAX_OUTS);
  localparam int unsigned QDepth = 1 << QW;
  localparam logic [CntW:0]  MaxOuts  = (CntW + 1)'(MAX_OUTS);
  localparam logic [PW-1:0]  LastPort = PW'(NUM_PORTS - 1);

  slot_e             slot_q, slot_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [SizeW-1:0]  size_q, size_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [LockW-1:0]  lock_q, lock_d;
  logic              write_q, write_d;
  logic [PW-1:0]     port_q, port_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   wr_outs_q, wr_outs_d, rd_outs_q, rd_outs_d;
  logic [PW-1:0]     fifo_q [QDepth];
  logic [PW-1:0]     fifo_d [QDepth];
  logic [QW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   fcnt_q, fcnt_d;

  logic                 arw_fire, can_load, load, win_valid, wr_ok, rd_ok;
  logic                 push, rd_inc, wr_dec, rd_dec, pop;
  logic [CntW:0]        wr_pend, rd_pend;
  logic [NUM_PORTS-1:0] elig, arb_req, gnt;
  logic [PW-1:0]        win_idx;

  always_comb begin
    arw_fire = (slot_q == SlotFull) && bus.io_ddr_arw_ready;
    can_load = (slot_q == SlotEmpty) || arw_fire;
    // A full slot already holds one burst of its direction, so count it against the limit.
    wr_pend  = {1'b0, wr_outs_q} + {{CntW{1'b0}}, (slot_q == SlotFull) && write_q};
    rd_pend  = {1'b0, rd_outs_q} + {{CntW{1'b0}}, (slot_q == SlotFull) && !write_q};
    wr_ok    = wr_pend < MaxOuts;
    rd_ok    = rd_pend < MaxOuts;
    elig     = bus.req_valid & ((bus.req_write & {NUM_PORTS{wr_ok}}) |
                                (~bus.req_write & {NUM_PORTS{rd_ok}}));
`ifdef ARW_ARB_WR_PRIORITY_EN
    arb_req  = (|(elig & bus.req_write)) ? (elig & bus.req_write) : elig;
`else
    arb_req  = elig;
`endif
  end

  rr_arbiter #(
    .NumPorts(NUM_PORTS),
    .PtrW    (PW)
  ) u_rr (
    .req_i  (arb_req),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win_idx),
    .valid_o(win_valid)
  );

  always_comb begin
    load          = can_load && win_valid && !dma_reset;
    bus.req_ready = load ? gnt : '0;
    slot_d   = slot_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    lock_d   = lock_q;
    write_d  = write_q;
    port_d   = port_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      slot_d   = SlotFull;
      port_d   = win_idx;
      rr_ptr_d = (win_idx == LastPort) ? '0 : win_idx + 1'b1;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (gnt[i]) begin
          addr_d  = bus.req_addr[i*AW +: AW];
          len_d   = bus.req_len[i*LenW +: LenW];
          size_d  = bus.req_size[i*SizeW +: SizeW];
          burst_d = bus.req_burst[i*BurstW +: BurstW];
          lock_d  = bus.req_lock[i*LockW +: LockW];
          write_d = bus.req_write[i];
        end
      end
    end else if (arw_fire) begin
      slot_d = SlotEmpty;
    end
  end

  always_comb begin
    push   = arw_fire && write_q;
    rd_inc = arw_fire && !write_q;
    wr_dec = bus.b_fire && (wr_outs_q != '0);
    rd_dec = bus.r_last_fire && (rd_outs_q != '0);
    pop    = bus.w_last_fire && (fcnt_q != '0);

    wr_outs_d = wr_outs_q;
    if (push && !wr_dec)      wr_outs_d = wr_outs_q + 1'b1;
    else if (!push && wr_dec) wr_outs_d = wr_outs_q - 1'b1;
    rd_outs_d = rd_outs_q;
    if (rd_inc && !rd_dec)      rd_outs_d = rd_outs_q + 1'b1;
    else if (!rd_inc && rd_dec) rd_outs_d = rd_outs_q - 1'b1;

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (push) begin
      fifo_d[wptr_q] = port_q;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge dma_clk) begin
    if (dma_reset) begin
      slot_q    <= SlotEmpty;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      lock_q    <= '0;
      write_q   <= 1'b0;
      port_q    <= '0;
      rr_ptr_q  <= '0;
      wr_outs_q <= '0;
      rd_outs_q <= '0;
      fifo_q    <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      lock_q    <= lock_d;
      write_q   <= write_d;
      port_q    <= port_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_outs_q <= wr_outs_d;
      rd_outs_q <= rd_outs_d;
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.io_ddr_arw_valid         = (slot_q == SlotFull);
  assign bus.io_ddr_arw_payload_addr  = addr_q;
  assign bus.io_ddr_arw_payload_id    = ID_BASE + IdW'(port_q);
  assign bus.io_ddr_arw_payload_len   = len_q;
  assign bus.io_ddr_arw_payload_size  = size_q;
  assign bus.io_ddr_arw_payload_burst = burst_q;
  assign bus.io_ddr_arw_payload_lock  = lock_q;
  assign bus.io_ddr_arw_payload_write = write_q;
  assign bus.wr_order_valid           = (fcnt_q != '0);
  assign bus.wr_order_port            = (fcnt_q != '0) ? fifo_q[rptr_q] : '0;
  assign bus.wr_outs                  = wr_outs_q;
  assign bus.rd_outs                  = rd_outs_q;

endmodule

// File: tb/tb_ddr_arw_arbiter.sv
// Directed bench for ddr_arw_arbiter: a 2-port/MAX_OUTS=4 instance and a 3-port/MAX_OUTS=2 one.
module tb_ddr_arw_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  ddr_arw_arbiter_if #(.NUM_PORTS(2), .AW(32)) bus_a ();
  ddr_arw_arbiter_if #(.NUM_PORTS(3), .AW(32)) bus_b ();

  ddr_arw_arbiter #(.NUM_PORTS(2), .AW(32), .MAX_OUTS(4), .ID_BASE(8'hE0)) u_dut_a (
    .dma_clk  (clk),
    .dma_reset(rst),
    .bus      (bus_a)
  );

  ddr_arw_arbiter #(.NUM_PORTS(3), .AW(32), .MAX_OUTS(2), .ID_BASE(8'hE0)) u_dut_b (
    .dma_clk  (clk),
    .dma_reset(rst),
    .bus      (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_a.req_valid = '0; bus_a.req_write = '0;
    bus_a.req_addr  = {32'h0000_2000, 32'h0000_1000};
    bus_a.req_len   = {8'h03, 8'h07};
    bus_a.req_size  = {3'd2, 3'd3};
    bus_a.req_burst = {2'd1, 2'd1};
    bus_a.req_lock  = '0;
    bus_a.io_ddr_arw_ready = 1'b0;
    bus_a.w_last_fire = 1'b0; bus_a.b_fire = 1'b0; bus_a.r_last_fire = 1'b0;
    bus_b.req_valid = '0; bus_b.req_write = '0;
    bus_b.req_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    bus_b.req_len   = {8'h01, 8'h02, 8'h03};
    bus_b.req_size  = '0;
    bus_b.req_burst = '0;
    bus_b.req_lock  = '0;
    bus_b.io_ddr_arw_ready = 1'b0;
    bus_b.w_last_fire = 1'b0; bus_b.b_fire = 1'b0; bus_b.r_last_fire = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus_a.req_valid = 2'b11;
    bus_a.io_ddr_arw_ready = 1'b1;
    tick();
    tick();
    sample();
    vectors++; if (bus_a.req_ready !== 2'b00) begin miscompares++;
      $display("FAIL reset_ready got=%b want=00", bus_a.req_ready); end
    vectors++; if (bus_a.io_ddr_arw_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid got=%b want=0", bus_a.io_ddr_arw_valid); end
    vectors++; if (bus_a.io_ddr_arw_payload_id !== 8'hE0) begin miscompares++;
      $display("FAIL reset_id got=%h want=e0", bus_a.io_ddr_arw_payload_id); end
    vectors++; if (bus_a.io_ddr_arw_payload_addr !== 32'h0) begin miscompares++;
      $display("FAIL reset_addr got=%h want=0", bus_a.io_ddr_arw_payload_addr); end
    vectors++; if (bus_a.io_ddr_arw_payload_write !== 1'b0) begin miscompares++;
      $display("FAIL reset_write got=%b want=0", bus_a.io_ddr_arw_payload_write); end
    vectors++; if (bus_a.wr_outs !== 4'd0 || bus_a.rd_outs !== 4'd0) begin miscompares++;
      $display("FAIL reset_outs got=%0d/%0d want=0/0", bus_a.wr_outs, bus_a.rd_outs); end
    vectors++; if (bus_a.wr_order_valid !== 1'b0 || bus_a.wr_order_port !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_order got=%b/%0d want=0/0", bus_a.wr_order_valid, bus_a.wr_order_port);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0]  exp_id;
    logic [31:0] exp_addr;
    logic [1:0]  exp_rdy;
    apply_reset();
    bus_a.req_valid = 2'b11;
    bus_a.io_ddr_arw_ready = 1'b1;
    bus_a.r_last_fire = 1'b1;
    sample();
    vectors++; if (bus_a.req_ready !== 2'b01 || bus_a.io_ddr_arw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_first got=%b/%b want=01/0", bus_a.req_ready, bus_a.io_ddr_arw_valid);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      sample();
      exp_id   = (k % 2 == 1) ? 8'hE0 : 8'hE1;
      exp_addr = (k % 2 == 1) ? 32'h0000_1000 : 32'h0000_2000;
      exp_rdy  = (k % 2 == 1) ? 2'b10 : 2'b01;
      vectors++; if (bus_a.io_ddr_arw_valid !== 1'b1) begin miscompares++;
        $display("FAIL rr_valid k=%0d got=%b want=1", k, bus_a.io_ddr_arw_valid); end
      vectors++; if (bus_a.io_ddr_arw_payload_id !== exp_id) begin miscompares++;
        $display("FAIL rr_id k=%0d got=%h want=%h", k, bus_a.io_ddr_arw_payload_id, exp_id); end
      vectors++; if (bus_a.io_ddr_arw_payload_addr !== exp_addr) begin miscompares++;
        $display("FAIL rr_addr k=%0d got=%h want=%h", k, bus_a.io_ddr_arw_payload_addr, exp_addr);
      end
      vectors++; if (bus_a.req_ready !== exp_rdy) begin miscompares++;
        $display("FAIL rr_ready k=%0d got=%b want=%b", k, bus_a.req_ready, exp_rdy); end
    end
  endtask

  task automatic test_hold_stable();
    apply_reset();
    bus_a.req_valid = 2'b10;
    bus_a.req_write = 2'b10;
    bus_a.req_addr  = {32'hDEAD_0040, 32'h0000_1000};
    bus_a.req_len   = {8'h0F, 8'h07};
    sample();
    vectors++; if (bus_a.req_ready !== 2'b10) begin miscompares++;
      $display("FAIL hold_grant got=%b want=10", bus_a.req_ready); end
    tick();
    bus_a.req_valid = 2'b01;
    bus_a.req_write = 2'b00;
    bus_a.req_addr  = {32'hBAD0_0000, 32'h0000_1000};
    bus_a.req_len   = {8'hFF, 8'h07};
    for (int k = 0; k < 5; k++) begin
      sample();
      vectors++;
      if (bus_a.io_ddr_arw_valid !== 1'b1 || bus_a.io_ddr_arw_payload_addr !== 32'hDEAD_0040 ||
          bus_a.io_ddr_arw_payload_len !== 8'h0F || bus_a.io_ddr_arw_payload_write !== 1'b1 ||
          bus_a.io_ddr_arw_payload_id !== 8'hE1) begin
        miscompares++;
        $display("FAIL hold_payload k=%0d got=%b/%h/%h/%b/%h want=1/dead0040/0f/1/e1", k,
                 bus_a.io_ddr_arw_valid, bus_a.io_ddr_arw_payload_addr,
                 bus_a.io_ddr_arw_payload_len, bus_a.io_ddr_arw_payload_write,
                 bus_a.io_ddr_arw_payload_id);
      end
      vectors++; if (bus_a.req_ready !== 2'b00) begin miscompares++;
        $display("FAIL hold_ready k=%0d got=%b want=00", k, bus_a.req_ready); end
      tick();
    end
    bus_a.io_ddr_arw_ready = 1'b1;
    sample();
    vectors++; if (bus_a.req_ready !== 2'b01) begin miscompares++;
      $display("FAIL hold_accept_ready got=%b want=01", bus_a.req_ready); end
    tick();
    sample();
    vectors++;
    if (bus_a.io_ddr_arw_payload_id !== 8'hE0 || bus_a.io_ddr_arw_payload_write !== 1'b0 ||
        bus_a.io_ddr_arw_payload_addr !== 32'h0000_1000) begin
      miscompares++;
      $display("FAIL hold_next got=%h/%b/%h want=e0/0/00001000", bus_a.io_ddr_arw_payload_id,
               bus_a.io_ddr_arw_payload_write, bus_a.io_ddr_arw_payload_addr);
    end
    vectors++;
    if (bus_a.wr_outs !== 4'd1 || bus_a.wr_order_valid !== 1'b1 ||
        bus_a.wr_order_port !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_wr_state got=%0d/%b/%0d want=1/1/1", bus_a.wr_outs,
               bus_a.wr_order_valid, bus_a.wr_order_port);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    bus_a.req_valid = 2'b11;
    bus_a.req_write = 2'b10;
    bus_a.io_ddr_arw_ready = 1'b1;
    sample();
`ifdef ARW_ARB_WR_PRIORITY_EN
    vectors++; if (bus_a.req_ready !== 2'b10) begin miscompares++;
      $display("FAIL prio_ready got=%b want=10", bus_a.req_ready); end
    tick();
    sample();
    vectors++; if (bus_a.io_ddr_arw_payload_id !== 8'hE1 ||
                   bus_a.io_ddr_arw_payload_write !== 1'b1) begin miscompares++;
      $display("FAIL prio_first got=%h/%b want=e1/1", bus_a.io_ddr_arw_payload_id,
               bus_a.io_ddr_arw_payload_write); end
`else
    vectors++; if (bus_a.req_ready !== 2'b01) begin miscompares++;
      $display("FAIL prio_ready got=%b want=01", bus_a.req_ready); end
    tick();
    sample();
    vectors++; if (bus_a.io_ddr_arw_payload_id !== 8'hE0 ||
                   bus_a.io_ddr_arw_payload_write !== 1'b0) begin miscompares++;
      $display("FAIL prio_first got=%h/%b want=e0/0", bus_a.io_ddr_arw_payload_id,
               bus_a.io_ddr_arw_payload_write); end
`endif
  endtask

  task automatic test_out_limit();
    logic [3:0] exp_wr [7]  = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd1, 4'd1, 4'd2};
    logic [2:0] exp_rdy [7] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    logic       exp_vld [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    bus_b.req_valid = 3'b001;
    bus_b.req_write = 3'b001;
    bus_b.io_ddr_arw_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      bus_b.b_fire = (k == 3);
      bus_b.w_last_fire = (k == 3);
      sample();
      vectors++;
      if (bus_b.wr_outs !== exp_wr[k] || bus_b.req_ready !== exp_rdy[k] ||
          bus_b.io_ddr_arw_valid !== exp_vld[k]) begin
        miscompares++;
        $display("FAIL limit k=%0d got=%0d/%b/%b want=%0d/%b/%b", k, bus_b.wr_outs,
                 bus_b.req_ready, bus_b.io_ddr_arw_valid, exp_wr[k], exp_rdy[k], exp_vld[k]);
      end
    end
  endtask

  task automatic test_write_order();
    logic [2:0] req_v   [8] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
    logic       fire    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       wl_only [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_rdy [8] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
    logic       exp_ov  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_op  [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [3:0] exp_wr  [8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
    apply_reset();
    bus_b.req_write = 3'b111;
    bus_b.io_ddr_arw_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      bus_b.req_valid   = req_v[k];
      bus_b.b_fire      = fire[k] || (k == 6);
      bus_b.w_last_fire = fire[k] || wl_only[k];
      sample();
      vectors++;
      if (bus_b.req_ready !== exp_rdy[k] || bus_b.wr_order_valid !== exp_ov[k] ||
          bus_b.wr_order_port !== exp_op[k] || bus_b.wr_outs !== exp_wr[k]) begin
        miscompares++;
        $display("FAIL order k=%0d got=%b/%b/%0d/%0d want=%b/%b/%0d/%0d", k, bus_b.req_ready,
                 bus_b.wr_order_valid, bus_b.wr_order_port, bus_b.wr_outs,
                 exp_rdy[k], exp_ov[k], exp_op[k], exp_wr[k]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    bus_b.req_valid = 3'b011;
    bus_b.req_write = 3'b001;
    bus_b.io_ddr_arw_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus_b.io_ddr_arw_ready = 1'b0;
    sample();
    vectors++;
    if (bus_b.io_ddr_arw_valid !== 1'b1 || bus_b.wr_outs !== 4'd2 || bus_b.rd_outs !== 4'd1 ||
        bus_b.wr_order_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre got=%b/%0d/%0d/%b want=1/2/1/1", bus_b.io_ddr_arw_valid,
               bus_b.wr_outs, bus_b.rd_outs, bus_b.wr_order_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_b.req_valid = '0;
    sample();
    vectors++;
    if (bus_b.io_ddr_arw_valid !== 1'b0 || bus_b.wr_outs !== 4'd0 || bus_b.rd_outs !== 4'd0 ||
        bus_b.wr_order_valid !== 1'b0 || bus_b.io_ddr_arw_payload_id !== 8'hE0) begin
      miscompares++;
      $display("FAIL midrst_post got=%b/%0d/%0d/%b/%h want=0/0/0/0/e0", bus_b.io_ddr_arw_valid,
               bus_b.wr_outs, bus_b.rd_outs, bus_b.wr_order_valid, bus_b.io_ddr_arw_payload_id);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_hold_stable();
    test_priority();
    test_out_limit();
    test_write_order();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_arw_arbiter.md
# ddr_arw_arbiter

- Parametrised N-port arbiter that merges AXI-style read and write address requests from DMA/accelerator masters onto the single shared DDR ARW port.
- Successor to the fixed two-source (one AW, one AR) address mux: adds round-robin arbitration over `NUM_PORTS` requesters, a registered output slot with full throughput, per-direction outstanding-burst limits, and a write-order queue that tells the downstream W-data mux which port owns the next write burst.
- Sits between the DMA cores and the DDR controller, in the `dma_clk` domain.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requesters, 1..8; `PW` = max(1, clog2(`NUM_PORTS`)).
- `AW`, 32, address width.
- `MAX_OUTS`, 4, maximum outstanding bursts per direction, 1..15.
- `ID_BASE`, 8'hE0, value added to the port index to form the DDR ID.

Ports:
- `dma_clk`  in  1  clock; one clock; all logic on the rising edge.
- `dma_reset`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_PORTS  per-port request valid.
- `req_ready`  out  NUM_PORTS  per-port accept.
- `req_write`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*AW  packed addresses; port i at [i*AW +: AW].
- `req_len`  in  NUM_PORTS*8  burst length minus 1.
- `req_size`  in  NUM_PORTS*3  beat size.
- `req_burst`  in  NUM_PORTS*2  burst type.
- `req_lock`  in  NUM_PORTS*2  lock.
- `io_ddr_arw_valid`  out  1  ARW valid.
- `io_ddr_arw_ready`  in  1  ARW ready.
- `io_ddr_arw_payload_addr`  out  AW  address.
- `io_ddr_arw_payload_id`  out  8  ID = `ID_BASE` + granted port index (mod 256).
- `io_ddr_arw_payload_len`  out  8  burst length minus 1.
- `io_ddr_arw_payload_size`  out  3  beat size.
- `io_ddr_arw_payload_burst`  out  2  burst type.
- `io_ddr_arw_payload_lock`  out  2  lock.
- `io_ddr_arw_payload_write`  out  1  1 = write.
- `w_last_fire`  in  1  W last-beat handshake observed downstream.
- `b_fire`  in  1  B handshake.
- `r_last_fire`  in  1  R last-beat handshake.
- `wr_order_valid`  out  1  write-order queue not empty.
- `wr_order_port`  out  PW  port that owns the current write burst.
- `wr_outs`  out  4  outstanding write bursts.
- `rd_outs`  out  4  outstanding read bursts.

## Operation
Eligibility:
- Port i is eligible when `req_valid[i]` is high and its direction counter is below `MAX_OUTS`.

Output slot, states EMPTY and FULL:
- The slot may load when it is EMPTY, or when it is FULL and `io_ddr_arw_ready` is high in the same cycle.
- On load, the combinational round-robin winner among eligible ports gets `req_ready[i]` = 1 in that cycle, and its payload is registered.
- Transitions: FULL stays FULL on a back-to-back load; FULL goes to EMPTY when ARW is accepted and there is no new winner.
- `io_ddr_arw_valid` = slot FULL.
- Payload is held stable while valid is high and ready is low.

Round-robin:
- Pointer `rr_ptr` is reset to 0.
- The search starts at `rr_ptr` and wraps modulo `NUM_PORTS`.
- After a grant to port g, `rr_ptr` = (g+1) mod `NUM_PORTS`.

Counters:
- `wr_outs` +1 on an ARW handshake with write = 1; −1 on `b_fire`.
- `rd_outs` +1 on an ARW handshake with write = 0; −1 on `r_last_fire`.
- A simultaneous increment and decrement leaves the counter unchanged.
- Eligibility uses the counter plus the slot contents: a FULL slot of that direction counts as outstanding, so the limit is never exceeded.
- A decrement at 0 (spurious) is ignored.

Write-order FIFO:
- Depth `MAX_OUTS`, entries `PW` wide.
- Push: the granted port index on a write ARW handshake.
- Pop: on `w_last_fire`.
- Push and pop in the same cycle are both applied.
- Pop when empty is ignored.
- It cannot overflow, because occupancy ≤ `wr_outs`.

## Timing
- Latency: `req_valid` to `io_ddr_arw_valid` is 1 cycle. Full throughput is one request per cycle while ready stays high.
- `req_ready` is combinational from `req_valid`, the counters, the slot state and `io_ddr_arw_ready`.
- Reset values:
  - all `req_ready` = 0 while `dma_reset` is high;
  - `io_ddr_arw_valid` = 0, payload = 0, id = `ID_BASE`, write = 0;
  - `wr_outs` = `rd_outs` = 0; `wr_order_valid` = 0; `wr_order_port` = 0; `rr_ptr` = 0.
- Reset mid-burst discards the slot, the counters and the FIFO without completion; the DDR side must be reset together with this block.

## Configuration
- `ARW_ARB_WR_PRIORITY_EN` defined: any eligible write beats all reads, with round-robin within each class. One shared pointer still advances past the granted port.
- Not defined: pure round-robin that ignores direction.

## Structure
- Shared package `ddr_arw_pkg`: payload field widths (LEN 8, SIZE 3, BURST 2, LOCK 2, ID 8), the `ID_BASE` default, and the slot state encoding.
- One natural sub-module: `rr_arbiter` (parametrised NUM_PORTS; request vector, pointer → one-hot grant plus index).
- The FIFO is inline.

## Test plan
1. Ports 0 and 1 request continuously (reads), ready held high → grants alternate 0,1,0,1; arw_valid every cycle; ids E0,E1 alternating.
2. Port 1 write with `io_ddr_arw_ready` held low for 5 cycles → addr/len/write stable for all 5 cycles; `req_ready[0]` stays 0 until accept.
3. MAX_OUTS=2, three writes issued, no `b_fire` → third is not granted; one `b_fire` → granted the next cycle; `wr_outs` sequence 1,2,2→1→2.
4. Writes from ports 2,0,1 → `wr_order_port` 2,0,1 on successive `w_last_fire`; push+pop in the same cycle keeps occupancy.
5. With `ARW_ARB_WR_PRIORITY_EN`: read on port 0 and write on port 1 both pending → port 1 granted first. Without the macro → port 0 granted first.
6. Assert `dma_reset` with the slot FULL and counters at 2 → next cycle valid = 0, counters = 0, `wr_order_valid` = 0.
